pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It watches the fetch hit bit, the IF/ID source registers, the ID/EX load destination and the EX/MEM branch decision. From these it drives the PC write enable, the IF/ID write enable and per-register flushes, and it runs the instruction-refill handshake on a fetch miss. Two saturating performance counters, stall cycles and branch flushes, are exposed for debug.

## Interface

Parameters:
- REFILL_TIMEOUT, 64: number of cycles in REFILL without mem_ready before refill_req is re-issued; legal range 2..255.
- PERF_W, 32: width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_hit  in  1  fetch stage cache hit for the current PC.
- mem_ready  in  1  instruction memory refill complete; sampled only in REFILL.
- id_rs  in  5  rs field of the IF/ID instruction.
- id_rt  in  5  rt field of the IF/ID instruction.
- ex_mem_read  in  1  MemRead of the ID/EX register.
- ex_rt  in  5  rt of the ID/EX register, i.e. the load destination.
- mem_branch_taken  in  1  PCSrc (Branch AND zero) from EX/MEM.
- perf_clr  in  1  synchronous clear of both counters.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  load a bubble (all-zero instruction, hit=0) into IF/ID.
- id_ex_flush  out  1  zero all ID/EX control bits.
- ex_mem_flush  out  1  zero all EX/MEM control bits.
- refill_req  out  1  single-cycle registered refill request.
- refill_abort  out  1  combinational pulse: an outstanding refill was cancelled.
- stall_cycles  out  PERF_W  count of cycles with pc_write=0 (saturating).
- branch_flushes  out  PERF_W  count of taken-branch flushes (saturating).

## Operation

- States: RUN, REFILL, RESUME. Reset state is RUN.
- Load-use hazard (LU) = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- Default outputs: pc_write=1, if_id_write=1, all flushes 0.
- RUN, evaluated in priority order:
  1. mem_branch_taken: assert if_id_flush, id_ex_flush and ex_mem_flush; pc_write=1 so the PC loads the target. if_hit and LU are ignored. Stay in RUN.
  2. !if_hit: pc_write=0, if_id_flush=1. Go to REFILL.
  3. LU: pc_write=0, if_id_write=0, id_ex_flush=1. Stay in RUN.
- REFILL: pc_write=0, if_id_flush=1 every cycle; stages downstream of IF/ID keep flowing.
  - mem_branch_taken: apply the full branch flush, refill_abort=1, go to RUN. This takes priority over mem_ready in the same cycle.
  - Otherwise mem_ready: go to RESUME.
  - Otherwise, when the timeout timer equals REFILL_TIMEOUT-1: reset the timer to 0 and pulse refill_req on the next cycle.
- RESUME: one cycle with pc_write=0 and if_id_flush=1, which lets the cache array write settle. A branch here behaves as in REFILL, without refill_abort. Then go to RUN.
- refill_req is high for exactly the first cycle spent in REFILL and for each re-issue. It is never high in RUN or RESUME.
- Counters:
  - stall_cycles increments every cycle with pc_write=0.
  - branch_flushes increments every cycle with mem_branch_taken=1 in any state.
  - Both hold at all-ones.
  - perf_clr has priority over increment; the counter reads 0 on the next cycle.

## Timing

- Stall and flush outputs are combinational from state and inputs, so they take effect at the same edge. refill_req and the counters are registered.
- While rst is high: state=RUN, timer=0, refill_req=0, counters=0, and pc_write, if_id_write and all flushes are forced to 0.
- An LU stall lasts exactly 1 cycle for a single dependent load.
- Minimum miss penalty: 1 cycle to enter REFILL, plus a REFILL dwell of at least 1 cycle, plus 1 cycle in RESUME. With mem_ready asserted in the first REFILL cycle, pc_write is 0 for 3 cycles.
- A miss during a taken branch is dropped. The redirected PC is fetched and re-evaluated on the next cycle.
- The timeout timer is 8 bits wide, is cleared on REFILL entry, and counts only in REFILL.

## Structure

- Shared package/header mips_ctrl_pkg holds:
  - state encodings: RUN=2'd0, REFILL=2'd1, RESUME=2'd2;
  - REG_ZERO=5'd0;
  - the bubble instruction constant 32'h0.
- One sub-module, sat_counter (parameter W; inputs inc and clr), instantiated twice for the performance counters.
- The remaining FSM, timer and hazard compare logic live in pipeline_hazard_ctrl.

## Test plan

- Load-use stall: ex_mem_read=1, ex_rt=5'd8, id_rs=5'd8, if_hit=1. Expect pc_write=0, if_id_write=0 and id_ex_flush=1 for 1 cycle, then stall_cycles=1. Repeat with ex_rt=0 and expect no stall.
- Miss with fast refill: if_hit=0 in RUN. Expect refill_req high on the next cycle. Assert mem_ready in that cycle; expect RESUME, then RUN, with exactly 3 stall cycles.
- Timeout: REFILL_TIMEOUT=4, hold mem_ready=0. Expect refill_req pulses at REFILL cycles 1, 5 and 9, with pc_write=0 throughout.
- Branch wins: in REFILL, assert mem_branch_taken and mem_ready together. Expect all three flushes, refill_abort=1, the next state RUN, and branch_flushes incremented by 1.
- Branch over hazard: in RUN, assert mem_branch_taken=1, if_hit=0 and LU together. Expect pc_write=1, all flushes asserted, no REFILL entry and no refill_req.
- Reset and saturation:
  - Assert rst mid-REFILL. Expect all outputs 0 asynchronously and the state RUN after release.
  - With PERF_W=4, perform 20 stalls. Expect stall_cycles=4'hF, then perf_clr returns it to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and helpers for the MIPS pipeline control blocks.
// Holds the hazard-sequencer states, register-zero constant and the IF/ID bubble.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    RESUME = 2'd2
  } state_e;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [31:0] BUBBLE_INSN = 32'h0;

  // A load into $zero never creates a real dependency.
  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] ld_rt,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
    return mem_read && (ld_rt != REG_ZERO) && ((ld_rt == rs) || (ld_rt == rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear that overrides increment.
// Used for the debug performance counters of the hazard sequencer.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes and the instruction-refill handshake on a fetch miss.
module pipeline_hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int REFILL_TIMEOUT = 64,
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_hit,
  input  logic              mem_ready,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              mem_branch_taken,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              refill_req,
  output logic              refill_abort,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] branch_flushes
);

  localparam logic [7:0] TIMER_LAST = 8'(REFILL_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       refill_req_q, refill_req_d;
  logic       lu_hazard, timeout;
  logic       pc_write_c, if_id_write_c, if_id_flush_c;
  logic       id_ex_flush_c, ex_mem_flush_c, refill_abort_c;

  assign lu_hazard = load_use(ex_mem_read, ex_rt, id_rs, id_rt);
  assign timeout   = (timer_q == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      timer_q      <= '0;
      refill_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      refill_req_q <= refill_req_d;
    end
  end

  // Timer is zero outside REFILL, so it is already cleared on every entry.
  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    refill_req_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!mem_branch_taken && !if_hit) begin
          state_d      = REFILL;
          refill_req_d = 1'b1;
        end
      end
      REFILL: begin
        if (mem_branch_taken) begin
          state_d = RUN;
        end else if (mem_ready) begin
          state_d = RESUME;
        end else begin
          timer_d      = timeout ? 8'd0 : timer_q + 8'd1;
          refill_req_d = timeout;
        end
      end
      RESUME:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // A taken branch always reloads the PC so the redirect target is not lost.
  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    refill_abort_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_branch_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_flush_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
        end else if (!if_hit) begin
          pc_write_c    = 1'b0;
          if_id_flush_c = 1'b1;
        end else if (lu_hazard) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_flush_c = 1'b1;
        end
      end
      REFILL, RESUME: begin
        pc_write_c    = 1'b0;
        if_id_flush_c = 1'b1;
        if (mem_branch_taken) begin
          pc_write_c     = 1'b1;
          id_ex_flush_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
          refill_abort_c = (state_q == REFILL);
        end
      end
      default: ;
    endcase
  end

  assign pc_write     = pc_write_c     & ~rst;
  assign if_id_write  = if_id_write_c  & ~rst;
  assign if_id_flush  = if_id_flush_c  & ~rst;
  assign id_ex_flush  = id_ex_flush_c  & ~rst;
  assign ex_mem_flush = ex_mem_flush_c & ~rst;
  assign refill_abort = refill_abort_c & ~rst;
  assign refill_req   = refill_req_q;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_write_c),
    .clr   (perf_clr),
    .count (stall_cycles)
  );

  sat_counter #(.W(PERF_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_branch_taken),
    .clr   (perf_clr),
    .count (branch_flushes)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: decode table, directed multi-cycle sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int PW   = 4;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_hit = 1'b1, mem_ready = 1'b0, ex_mem_read = 1'b0;
  logic          mem_branch_taken = 1'b0, perf_clr = 1'b0;
  logic [4:0]    id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic          refill_req, refill_abort;
  logic [PW-1:0] stall_cycles, branch_flushes;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = running, 1 = waiting for memory, 2 = one settle cycle.
  int m_phase = 0;
  int m_rcyc  = 0;
  int m_stall = 0;
  int m_brc   = 0;

  logic          s_pc, s_ifw, s_iff, s_idex, s_exm, s_abort, s_req;
  logic [PW-1:0] s_stall, s_brc;

  pipeline_hazard_ctrl #(.REFILL_TIMEOUT(TMO), .PERF_W(PW)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_hit           (if_hit),
    .mem_ready        (mem_ready),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .perf_clr         (perf_clr),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .refill_req       (refill_req),
    .refill_abort     (refill_abort),
    .stall_cycles     (stall_cycles),
    .branch_flushes   (branch_flushes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic hit, input logic ready, input logic [4:0] rs,
                      input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                      input logic br, input logic clr);
    logic e_pc, e_ifw, e_iff, e_idex, e_exm, e_abort, e_req, lu;
    int   nphase, nrcyc;
    @(negedge clk);
    if_hit = hit; mem_ready = ready; id_rs = rs; id_rt = rt;
    ex_mem_read = mr; ex_rt = xrt; mem_branch_taken = br; perf_clr = clr;
    #1;
    lu = mr && (xrt != 5'd0) && ((xrt == rs) || (xrt == rt));
    e_pc = 1'b1; e_ifw = 1'b1; e_iff = 1'b0; e_idex = 1'b0; e_exm = 1'b0; e_abort = 1'b0;
    e_req  = (m_phase == 1) && (((m_rcyc - 1) % TMO) == 0);
    nphase = m_phase;
    nrcyc  = m_rcyc;
    if (m_phase == 0) begin
      if (br) begin
        e_iff = 1'b1; e_idex = 1'b1; e_exm = 1'b1;
      end else if (!hit) begin
        e_pc = 1'b0; e_iff = 1'b1; nphase = 1; nrcyc = 1;
      end else if (lu) begin
        e_pc = 1'b0; e_ifw = 1'b0; e_idex = 1'b1;
      end
    end else begin
      e_pc = 1'b0; e_iff = 1'b1;
      if (br) begin
        e_pc = 1'b1; e_idex = 1'b1; e_exm = 1'b1; e_abort = (m_phase == 1); nphase = 0;
      end else if (m_phase == 1 && ready) begin
        nphase = 2;
      end else if (m_phase == 1) begin
        nrcyc = m_rcyc + 1;
      end else begin
        nphase = 0;
      end
    end
    s_pc = pc_write; s_ifw = if_id_write; s_iff = if_id_flush; s_idex = id_ex_flush;
    s_exm = ex_mem_flush; s_abort = refill_abort; s_req = refill_req;
    s_stall = stall_cycles; s_brc = branch_flushes;
    chk("pc_write",       32'(pc_write),       32'(e_pc));
    chk("if_id_write",    32'(if_id_write),    32'(e_ifw));
    chk("if_id_flush",    32'(if_id_flush),    32'(e_iff));
    chk("id_ex_flush",    32'(id_ex_flush),    32'(e_idex));
    chk("ex_mem_flush",   32'(ex_mem_flush),   32'(e_exm));
    chk("refill_abort",   32'(refill_abort),   32'(e_abort));
    chk("refill_req",     32'(refill_req),     32'(e_req));
    chk("stall_cycles",   32'(stall_cycles),   32'(m_stall));
    chk("branch_flushes", 32'(branch_flushes), 32'(m_brc));
    @(posedge clk);
    m_phase = nphase;
    m_rcyc  = nrcyc;
    if (clr) m_stall = 0;
    else if (!e_pc && m_stall < MAXC) m_stall++;
    if (clr) m_brc = 0;
    else if (br && m_brc < MAXC) m_brc++;
  endtask

  task automatic idle(input logic clr);
    step(1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, clr);
  endtask

  // Reset is applied with every comb output otherwise active, to prove the gating.
  task automatic reset_check();
    @(negedge clk);
    rst = 1'b1; if_hit = 1'b0; mem_branch_taken = 1'b1; mem_ready = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; perf_clr = 1'b0;
    #1;
    chk("rst_pc_write",     32'(pc_write),       32'd0);
    chk("rst_if_id_write",  32'(if_id_write),    32'd0);
    chk("rst_if_id_flush",  32'(if_id_flush),    32'd0);
    chk("rst_id_ex_flush",  32'(id_ex_flush),    32'd0);
    chk("rst_ex_mem_flush", 32'(ex_mem_flush),   32'd0);
    chk("rst_refill_req",   32'(refill_req),     32'd0);
    chk("rst_refill_abort", 32'(refill_abort),   32'd0);
    chk("rst_stall_cycles", 32'(stall_cycles),   32'd0);
    chk("rst_branch_flush", 32'(branch_flushes), 32'd0);
    m_phase = 0; m_rcyc = 0; m_stall = 0; m_brc = 0;
    @(negedge clk);
    rst = 1'b0; if_hit = 1'b1; mem_branch_taken = 1'b0; mem_ready = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
  endtask

  typedef struct {
    logic       hit;
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] xrt;
    logic       br;
    logic       e_pc, e_ifw, e_iff, e_idex, e_exm;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [PW-1:0] brc_before;
    tbl[0] = '{1'b1, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd8, 5'd3, 1'b0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 5'd4, 5'd5, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 5'd2, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    reset_check();

    // RUN-state decode table
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].hit, 1'b0, tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].xrt, tbl[i].br, 1'b0);
      chk($sformatf("tbl%0d_pc_write", i),     32'(s_pc),   32'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_if_id_write", i),  32'(s_ifw),  32'(tbl[i].e_ifw));
      chk($sformatf("tbl%0d_if_id_flush", i),  32'(s_iff),  32'(tbl[i].e_iff));
      chk($sformatf("tbl%0d_id_ex_flush", i),  32'(s_idex), 32'(tbl[i].e_idex));
      chk($sformatf("tbl%0d_ex_mem_flush", i), 32'(s_exm),  32'(tbl[i].e_exm));
    end

    // Single load-use stall lasts one cycle and counts once
    idle(1'b1);
    step(1'b1, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
    idle(1'b0);
    chk("lu_release_pc", 32'(s_pc), 32'd1);
    chk("lu_stall_count", 32'(s_stall), 32'd1);

    // Miss with refill ready in the first REFILL cycle
    idle(1'b1);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("fast_refill_req", 32'(s_req), 32'd1);
    idle(1'b0);
    chk("fast_resume_pc", 32'(s_pc), 32'd0);
    chk("fast_resume_req", 32'(s_req), 32'd0);
    idle(1'b0);
    chk("fast_run_pc", 32'(s_pc), 32'd1);
    chk("fast_stall_count", 32'(s_stall), 32'd3);

    // Timeout re-issue: pulses at REFILL cycles 1, 5, 9
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      idle(1'b0);
      chk($sformatf("tmo_req_c%0d", k), 32'(s_req), 32'((k == 1) || (k == 5) || (k == 9)));
      chk($sformatf("tmo_pc_c%0d", k), 32'(s_pc), 32'd0);
    end
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b0);

    // Branch beats mem_ready in REFILL
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    brc_before = branch_flushes;
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("bw_abort", 32'(s_abort), 32'd1);
    chk("bw_flushes", 32'({s_iff, s_idex, s_exm}), 32'd7);
    idle(1'b0);
    chk("bw_run_pc", 32'(s_pc), 32'd1);
    chk("bw_no_req", 32'(s_req), 32'd0);
    chk("bw_branch_count", 32'(s_brc), 32'(brc_before) + 32'd1);

    // Branch over miss and load-use in RUN
    step(1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    chk("boh_pc", 32'(s_pc), 32'd1);
    chk("boh_flushes", 32'({s_iff, s_idex, s_exm}), 32'd7);
    idle(1'b0);
    chk("boh_no_req", 32'(s_req), 32'd0);
    chk("boh_no_refill", 32'(s_pc), 32'd1);

    // Reset in the middle of REFILL
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b0);
    reset_check();
    idle(1'b0);
    chk("post_rst_pc", 32'(s_pc), 32'd1);
    chk("post_rst_req", 32'(s_req), 32'd0);

    // Stall counter saturation and clear
    idle(1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(1'b1);
    chk("sat_stall", 32'(s_stall), 32'hF);
    idle(1'b0);
    chk("sat_cleared", 32'(s_stall), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
